// File: rtl/seg_scan_decoder_if.sv
// Scanned 7-segment display bus: the anode/segment lines coming in and the
// decoded view of the display going out.
// Optional feature macro: SEG_DP_EN adds the decimal-point line and its flags.
interface seg_scan_decoder_if;
  logic [3:0]  AN;           // anode enables, active-low, AN[i] selects digit i
  logic [6:0]  seg;          // segments, active-low, seg[0]=a .. seg[6]=g
  logic [15:0] digits;       // digit i in digits[4*i+3:4*i]
  logic [3:0]  digit_valid;  // digit i holds an accepted legal pattern
  logic [3:0]  blank;        // digit i last accepted as all-segments-off
  logic        frame_done;   // one-cycle pulse: all four digits accepted
  logic        bad_pattern;  // one-cycle pulse: accepted sample was illegal
`ifdef SEG_DP_EN
  logic        dp;           // decimal point, active-low
  logic [3:0]  dp_flags;     // decimal point lit on last legal accept of digit i

  modport master (output AN, seg, dp,
                  input  digits, digit_valid, blank, frame_done, bad_pattern, dp_flags);
  modport slave  (input  AN, seg, dp,
                  output digits, digit_valid, blank, frame_done, bad_pattern, dp_flags);
`else
  modport master (output AN, seg,
                  input  digits, digit_valid, blank, frame_done, bad_pattern);
  modport slave  (input  AN, seg,
                  output digits, digit_valid, blank, frame_done, bad_pattern);
`endif
endinterface

// File: rtl/seg_scan_decoder.sv
// Receiving end of a multiplexed 4-digit 7-segment display. Synchronises the
// scanned anode/segment lines, accepts a pattern only after it has been
// stable for STABLE_CYCLES samples, and decodes it back to a hex nibble.
// Optional feature macro: SEG_DP_EN (decimal point joins the sample and is
// reported per digit on dp_flags).
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,  // >= 2
  parameter int CNT_W         = 4   // must hold STABLE_CYCLES
) (
  input logic              CLOCK,
  input logic              RESET_N,
  seg_scan_decoder_if.slave bus
);

`ifdef SEG_DP_EN
  localparam int SW = 12;
  logic [SW-1:0] sample_in;
  assign sample_in = {bus.dp, bus.AN, bus.seg};
`else
  localparam int SW = 11;
  logic [SW-1:0] sample_in;
  assign sample_in = {bus.AN, bus.seg};
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [SW-1:0]    sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accepted_q, accepted_d;
  logic             accept;

  logic [3:0]  s_an;
  logic [6:0]  s_seg;
  assign s_an  = sync2_q[10:7];
  assign s_seg = sync2_q[6:0];

  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  seen_q, seen_d, seen_set;
  logic        frame_q, frame_d;
  logic        bad_q, bad_d;
  logic [1:0]  idx;
  logic        legal;
  logic [4:0]  dec;
`ifdef SEG_DP_EN
  logic [3:0]  dp_flags_q, dp_flags_d;
`endif

  // Map a standard hex glyph to {hit, nibble}; anything else returns hit=0.
  function automatic logic [4:0] glyph_to_hex(input logic [6:0] s);
    case (s)
      7'h40: return 5'h10;  7'h79: return 5'h11;
      7'h24: return 5'h12;  7'h30: return 5'h13;
      7'h19: return 5'h14;  7'h12: return 5'h15;
      7'h02: return 5'h16;  7'h78: return 5'h17;
      7'h00: return 5'h18;  7'h10: return 5'h19;
      7'h08: return 5'h1A;  7'h03: return 5'h1B;
      7'h46: return 5'h1C;  7'h21: return 5'h1D;
      7'h06: return 5'h1E;  7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // Two-flop synchroniser; idle value is all lines high (nothing driven).
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sample_in;
      sync2_q <= sync1_q;
    end
  end

  // Run length of the synchronised value: sync1_q is what sync2_q becomes at
  // this edge, so a mismatch starts a new run of length 1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d      = cnt_q;
    accepted_d = accepted_q;
    accept     = (cnt_q == CNT_MAX) && !accepted_q;
    if (accept) accepted_d = 1'b1;
    if (sync1_q != sync2_q) begin
      cnt_d      = CNT_W'(1);
      accepted_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Run counter and once-per-run accept flag.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q      <= '0;
      accepted_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      accepted_q <= accepted_d;
    end
  end

  // Classify an accepted sample and compute the display state it implies.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    seen_d   = seen_q;
    seen_set = seen_q;
    frame_d  = 1'b0;
    bad_d    = 1'b0;
    legal    = 1'b0;
    idx      = 2'd0;
    dec      = glyph_to_hex(s_seg);
`ifdef SEG_DP_EN
    dp_flags_d = dp_flags_q;
`endif
    for (int i = 0; i < 4; i++) begin
      if (!s_an[i]) idx = 2'(i);
    end
    // All anodes high is inter-digit blanking and carries no information.
    if (accept && s_an != 4'hF) begin
      if ($onehot(~s_an)) begin
        if (dec[4]) begin
          digits_d[{idx, 2'b00} +: 4] = dec[3:0];
          valid_d[idx] = 1'b1;
          blank_d[idx] = 1'b0;
          legal        = 1'b1;
        end else if (s_seg == 7'h7F) begin
          digits_d[{idx, 2'b00} +: 4] = 4'h0;
          valid_d[idx] = 1'b1;
          blank_d[idx] = 1'b1;
          legal        = 1'b1;
        end else begin
          valid_d[idx] = 1'b0;
          blank_d[idx] = 1'b0;
          bad_d        = 1'b1;
        end
        if (legal) begin
          seen_set = seen_q | (4'b0001 << idx);
          if (seen_set == 4'hF) begin
            frame_d = 1'b1;
            seen_d  = 4'h0;
          end else begin
            seen_d = seen_set;
          end
`ifdef SEG_DP_EN
          dp_flags_d[idx] = ~sync2_q[11];
`endif
        end
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  // Decoded display state and status pulses.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      bad_q    <= 1'b0;
`ifdef SEG_DP_EN
      dp_flags_q <= '0;
`endif
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      bad_q    <= bad_d;
`ifdef SEG_DP_EN
      dp_flags_q <= dp_flags_d;
`endif
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.blank       = blank_q;
  assign bus.frame_done  = frame_q;
  assign bus.bad_pattern = bad_q;
`ifdef SEG_DP_EN
  assign bus.dp_flags    = dp_flags_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus randomized scanning,
// every cycle compared against a history-based reference model.
// Optional feature macro: SEG_DP_EN.
module tb_seg_scan_decoder;
  localparam int S = 4;
`ifdef SEG_DP_EN
  localparam int SW = 12;
`else
  localparam int SW = 11;
`endif

  logic CLOCK = 1'b0;
  logic RESET_N;
  seg_scan_decoder_if bus();

  seg_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(bus)
  );

  always #5 CLOCK = ~CLOCK;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;
  int frames_obs, bad_obs;

  // Reference model state: sampled inputs, newest at the back.
  logic [SW-1:0] hist[$];
  logic [15:0] e_digits;
  logic [3:0]  e_valid, e_blank, e_seen, e_dpf;
  logic        e_frame, e_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [SW-1:0] cur_sample();
`ifdef SEG_DP_EN
    return {bus.dp, bus.AN, bus.seg};
`else
    return {bus.AN, bus.seg};
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S + 3; k++) hist.push_back('1);
    e_digits = '0; e_valid = '0; e_blank = '0; e_seen = '0; e_dpf = '0;
    e_frame = 1'b0; e_bad = 1'b0;
  endtask

  // A value sampled at edges m-S-1..m-2, preceded by something different,
  // takes effect at edge m.
  task automatic model_edge();
    logic [SW-1:0] v;
    logic [3:0] an;
    logic [6:0] sg;
    int zeros, d, g;
    bit run_ok;
    e_frame = 1'b0;
    e_bad   = 1'b0;
    hist.push_back(cur_sample());
    while (hist.size() > S + 3) void'(hist.pop_front());
    v = hist[hist.size() - 3];
    run_ok = (hist[hist.size() - (S + 3)] != v);
    for (int k = 2; k <= S + 1; k++) if (hist[hist.size() - 1 - k] != v) run_ok = 0;
    if (!run_ok) return;
    an = v[10:7];
    sg = v[6:0];
    zeros = 4 - $countones(an);
    if (zeros == 0) return;
    if (zeros > 1) begin e_bad = 1'b1; return; end
    d = 0;
    for (int k = 0; k < 4; k++) if (an[k] == 1'b0) d = k;
    g = -1;
    for (int k = 0; k < 16; k++) if (GLYPH[k] == sg) g = k;
    if (g < 0 && sg != 7'h7F) begin
      e_valid[d] = 1'b0; e_blank[d] = 1'b0; e_bad = 1'b1;
      return;
    end
    e_digits[4*d +: 4] = (g < 0) ? 4'h0 : 4'(g);
    e_valid[d] = 1'b1;
    e_blank[d] = (g < 0);
`ifdef SEG_DP_EN
    e_dpf[d] = ~v[11];
`endif
    e_seen[d] = 1'b1;
    if (e_seen == 4'hF) begin e_frame = 1'b1; e_seen = 4'h0; end
  endtask

  task automatic compare_all();
    check("digits", bus.digits, e_digits);
    check("digit_valid", bus.digit_valid, e_valid);
    check("blank", bus.blank, e_blank);
    check("frame_done", bus.frame_done, e_frame);
    check("bad_pattern", bus.bad_pattern, e_bad);
`ifdef SEG_DP_EN
    check("dp_flags", bus.dp_flags, e_dpf);
`endif
    frames_obs += int'(bus.frame_done);
    bad_obs    += int'(bus.bad_pattern);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input logic dpv);
    bus.AN  = an;
    bus.seg = sg;
`ifdef SEG_DP_EN
    bus.dp  = dpv;
`endif
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] sg, input logic dpv, input int n);
    drive(an, sg, dpv);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK);
      if (RESET_N) model_edge();
      #2;
      compare_all();
    end
  endtask

  // Asynchronous reset applied mid-cycle, held for n edges.
  task automatic do_reset(input int n);
    RESET_N = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK);
      #2;
      compare_all();
    end
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [15:0] snap;
    RESET_N = 1'b0;
    drive(4'hE, 7'h00, 1'b1);
    model_reset();
    frames_obs = 0; bad_obs = 0;

    // Reset with digit 0 showing 8, then release.
    @(posedge CLOCK); #2;
    do_reset(3);
    step(4'hE, 7'h00, 1'b1, S + 1);
    check("rst_latency_early", bus.digit_valid[0], 1'b0);
    step(4'hE, 7'h00, 1'b1, 1);
    check("rst_latency_digit0", bus.digits[3:0], 4'h8);
    step(4'hE, 7'h00, 1'b1, 4);

    // Scan 1,2,3,4 with inter-digit blanking.
    drive(4'hF, 7'h7F, 1'b1);
    do_reset(1);
    frames_obs = 0; bad_obs = 0;
    for (int i = 0; i < 4; i++) begin
      step(~(4'b0001 << i), GLYPH[i + 1], (i == 1) ? 1'b0 : 1'b1, 8);
      step(4'hF, 7'h7F, 1'b1, 2);
    end
    step(4'hF, 7'h7F, 1'b1, 4);
    check("scan_digits", bus.digits, 16'h4321);
    check("scan_valid", bus.digit_valid, 4'hF);
    check("scan_frames", frames_obs, 1);
`ifdef SEG_DP_EN
    check("dp_flags_digit1", bus.dp_flags, 4'b0010);
`endif

    // Short glitch onto digit 2 inside a digit-0 window.
    frames_obs = 0; bad_obs = 0;
    step(4'hE, GLYPH[5], 1'b1, 3);
    step(4'hB, 7'h00, 1'b1, 2);
    step(4'hE, GLYPH[5], 1'b1, 8);
    step(4'hF, 7'h7F, 1'b1, 3);
    check("glitch_digit2", bus.digits[11:8], 4'h3);
    check("glitch_bad", bad_obs, 0);
    check("glitch_frames", frames_obs, 0);

    // Two anodes low: one bad pulse, digits unchanged.
    snap = bus.digits;
    bad_obs = 0;
    step(4'hC, GLYPH[7], 1'b1, 8);
    step(4'hF, 7'h7F, 1'b1, 3);
    check("multi_bad", bad_obs, 1);
    check("multi_digits", bus.digits, snap);

    // Non-hex segment pattern on digit 0.
    bad_obs = 0;
    step(4'hE, 7'h7E, 1'b1, 8);
    check("illegal_bad", bad_obs, 1);
    check("illegal_valid0", bus.digit_valid[0], 1'b0);
    step(4'hF, 7'h7F, 1'b1, 2);

    // All-segments-off on digit 3.
    step(4'h7, 7'h7F, 1'b1, 8);
    check("blank3", bus.blank[3], 1'b1);
    check("blank3_valid", bus.digit_valid[3], 1'b1);
    check("blank3_nibble", bus.digits[15:12], 4'h0);

    // Reset two samples into a run; nothing from that run may be accepted.
    step(4'hF, 7'h7F, 1'b1, 3);
    step(4'hD, GLYPH[2], 1'b1, 3);
    drive(4'hF, 7'h7F, 1'b1);
    do_reset(2);
    check("midrst_digits", bus.digits, 16'h0);
    step(4'hF, 7'h7F, 1'b1, 8);
    check("midrst_valid", bus.digit_valid, 4'h0);

    // Randomized scanning.
    for (int w = 0; w < 400; w++) begin
      logic [3:0] an;
      logic [6:0] sg;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 75)      an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 85) an = 4'hF;
      else             an = 4'($urandom());
      r = int'($urandom_range(0, 99));
      if (r < 70)      sg = GLYPH[$urandom_range(0, 15)];
      else if (r < 85) sg = 7'h7F;
      else             sg = 7'($urandom());
      step(an, sg, 1'($urandom()), int'($urandom_range(1, 9)));
      step(4'hF, 7'h7F, 1'b1, int'($urandom_range(0, 3)));
      if (w % 100 == 99) begin
        drive(4'hF, 7'h7F, 1'b1);
        do_reset(1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
